shift_stage: RTL and testbench
==============================

SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: stage can accept a request.
REQ-006 SHALL have port in_op, input, 3 bits: operation code.
- 000 SLL, 001 SRL, 010 SRA, 011 ROTR.
- 100 SLLV, 101 SRLV, 110 SRAV, 111 ROTRV.
REQ-007 SHALL have port in_a, input, 32 bits: operand to be shifted.
REQ-008 SHALL have port in_shamt, input, 5 bits: immediate shift amount, used when in_op[2]=0.
REQ-009 SHALL have port in_rs, input, 32 bits: register shift amount; only bits [4:0] used, when in_op[2]=1.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_result, output, 32 bits: shift result.
REQ-013 SHALL have port out_err, output, 1 bit: operation was illegal (qualified by out_valid).

Function
REQ-014 SHALL be a two-register pipeline.
- S1 holds decoded controls dirt, sign, rotate, amount[4:0] and operand.
- S2 holds result and err, produced by the combinational shifter instance fed from S1.
REQ-015 SHALL decode in_op.
- dirt = (op[1:0] != 00).
- sign = (op[1:0] == 10).
- rotate = (op[1:0] == 11).
- amount = op[2] ? in_rs[4:0] : in_shamt.
REQ-016 SHALL accept a request when in_valid & in_ready; latency from accept to out_valid is exactly 2 cycles with no backpressure.
REQ-017 SHALL drive in_ready = ~s1_valid | ~s2_valid | out_ready (combinational).
REQ-018 SHALL advance S1 into S2 when s1_valid & (~s2_valid | out_ready).
- S1 is loaded or emptied in the same cycle.
REQ-019 SHALL keep out_result and out_err stable while out_valid & ~out_ready.
REQ-020 SHALL sustain one result per cycle when out_ready is held high.
REQ-021 SHALL, on flush=1, clear s1_valid and s2_valid at the next edge.
- Flush has priority over accept and advance; the request offered that cycle is dropped.
REQ-022 SHALL, for amount 0, return in_a unchanged for every op.

Reset
REQ-023 SHALL, while rst_n=0, force s1_valid=0, s2_valid=0, out_result=0, out_err=0, S1 controls=0.
- Reset takes effect immediately, independent of clk.
- Reset mid-operation discards all in-flight requests.
REQ-024 SHALL drive in_ready=1 and out_valid=0 on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro SHIFT_ROTATE_EN.
- Defined: ops 011/111 perform right rotation; out_err is always 0.
- Undefined: ops 011/111 are illegal; they still flow through the pipeline with normal timing and handshake, and produce out_result=0, out_err=1.
- Undefined: no rotate logic is used (rotate tied 0).

Verification
REQ-026 SHALL cover: reset, then SRA with in_a=0x80000010 and in_shamt=4 -> 2 cycles later out_valid=1, out_result=0xF8000001, out_err=0.
REQ-027 SHALL cover: SLLV with in_a=0x00000001 and in_rs=0xFFFFFFFF (amount 31) -> out_result=0x80000000.
REQ-028 SHALL cover: ROTRV with in_a=0x12345678 and in_rs=8.
- With SHIFT_ROTATE_EN: out_result=0x78123456, out_err=0.
- Without it: out_result=0, out_err=1.
REQ-029 SHALL cover backpressure: 3 back-to-back SRL requests with out_ready=0.
- Required: in_ready drops after 2 accepts; results are held stable.
- Releasing out_ready yields all 3 results in order, with no loss or duplication.
REQ-030 SHALL cover: flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, the new request is not captured, in_ready=1.
REQ-031 SHALL cover: rst_n pulsed low mid-stream between edges -> out_valid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/shift_stage.sv
// shift_stage: two-register shift pipeline with valid/ready handshake.
// S1 holds decoded shift controls and the operand.
// S2 holds the registered shifter result and the illegal-op flag.
// Optional feature macro: SHIFT_ROTATE_EN.
//   - When defined, ops 011/111 perform a right rotation.
//   - When undefined, ops 011/111 are illegal: result 0, err 1.

// Combinational shifter, fed from the S1 registers
module shift_core (
   input  logic [31:0] a,
   input  logic [4:0]  amount,
   input  logic        dirt,
   input  logic        sign,
   input  logic        rotate,
   input  logic        illegal,
   output logic [31:0] result,
   output logic        err
);

   logic [63:0] rot_wide;

   // Rotation as a right shift of the operand concatenated with itself
   always_comb begin
      rot_wide = {a, a} >> amount;
   end

   // Select left, logical right, arithmetic right or rotate; illegal ops yield zero
   always_comb begin
      result = a;
      err    = 1'b0;
      if (illegal) begin
         result = '0;
         err    = 1'b1;
      end else if (rotate) begin
         result = rot_wide[31:0];
      end else if (!dirt) begin
         result = a << amount;
      end else if (sign) begin
         result = $unsigned($signed(a) >>> amount);
      end else begin
         result = a >> amount;
      end
   end

endmodule

module shift_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [4:0]  in_shamt,
   input  logic [31:0] in_rs,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_err
);

   // Decoded controls of the incoming request
   logic        dec_dirt;
   logic        dec_sign;
   logic        dec_rotate;
   logic        dec_illegal;
   logic [4:0]  dec_amount;

   // S1 registers
   logic        s1_valid;
   logic        s1_dirt;
   logic        s1_sign;
   logic        s1_rotate;
   logic        s1_illegal;
   logic [4:0]  s1_amount;
   logic [31:0] s1_a;

   // S2 registers
   logic        s2_valid;
   logic [31:0] s2_result;
   logic        s2_err;

   // Handshake and shifter wiring
   logic        accept;
   logic        advance;
   logic [31:0] core_result;
   logic        core_err;
   logic        unused_rs;

   // Upper register-amount bits are never used
   assign unused_rs = ^in_rs[31:5];

   // Decode op into shift controls
   always_comb begin
      dec_dirt   = (in_op[1:0] != 2'b00);
      dec_sign   = (in_op[1:0] == 2'b10);
      dec_amount = in_op[2] ? in_rs[4:0] : in_shamt;
`ifdef SHIFT_ROTATE_EN
      dec_rotate  = (in_op[1:0] == 2'b11);
      dec_illegal = 1'b0;
`else
      dec_rotate  = 1'b0;
      dec_illegal = (in_op[1:0] == 2'b11);
`endif
   end

   // Handshake: S1 moves on when S2 is empty or draining this cycle
   always_comb begin
      in_ready = ~s1_valid | ~s2_valid | out_ready;
      accept   = in_valid & in_ready;
      advance  = s1_valid & (~s2_valid | out_ready);
   end

   // S1 register: capture accepted request, empty on advance, cleared by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_dirt    <= 1'b0;
         s1_sign    <= 1'b0;
         s1_rotate  <= 1'b0;
         s1_illegal <= 1'b0;
         s1_amount  <= '0;
         s1_a       <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid   <= 1'b1;
         s1_dirt    <= dec_dirt;
         s1_sign    <= dec_sign;
         s1_rotate  <= dec_rotate;
         s1_illegal <= dec_illegal;
         s1_amount  <= dec_amount;
         s1_a       <= in_a;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   shift_core u_core (
      .a       (s1_a),
      .amount  (s1_amount),
      .dirt    (s1_dirt),
      .sign    (s1_sign),
      .rotate  (s1_rotate),
      .illegal (s1_illegal),
      .result  (core_result),
      .err     (core_err)
   );

   // S2 register: load on advance, hold while stalled, cleared by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_err    <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (advance) begin
         s2_valid  <= 1'b1;
         s2_result <= core_result;
         s2_err    <= core_err;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   // Outputs come straight from S2
   always_comb begin
      out_valid  = s2_valid;
      out_result = s2_result;
      out_err    = s2_err;
   end

endmodule

// File: tb/tb_shift_stage.sv
// tb_shift_stage: table-driven vectors through a scoreboard queue, plus
// hand-written latency, backpressure, flush and async-reset sequences.
// Build with or without SHIFT_ROTATE_EN; rotate expectations follow the macro.
module tb_shift_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [4:0]  in_shamt;
   logic [31:0] in_rs;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_err;

   typedef struct packed {
      logic [31:0] r;
      logic        e;
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [4:0]  sh;
      logic [31:0] rs;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   exp_t        sbq[$];
   exp_t        drv_exp;
   exp_t        got;
   vec_t        tbl[14];
   int          errors;
   int          checks;
   logic        held_v;
   logic [31:0] held_r;
   logic        held_e;

   shift_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_rs      (in_rs),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: hold stability, pop on output transfer, push on accepted input
   always @(negedge clk) begin
      if (rst_n) begin
         if (held_v) begin
            chk("hold_result", out_result, held_r);
            chk("hold_err", {31'd0, out_err}, {31'd0, held_e});
         end
         if (out_valid && !out_ready) begin
            held_v = 1'b1;
            held_r = out_result;
            held_e = out_err;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", out_result);
            end else begin
               got = sbq.pop_front();
               chk("result", out_result, got.r);
               chk("err", {31'd0, out_err}, {31'd0, got.e});
            end
         end
         if (flush) sbq.delete();
         else if (in_valid && in_ready) sbq.push_back(drv_exp);
      end else begin
         sbq.delete();
         held_v = 1'b0;
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] er, input logic ee);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_shamt = sh;
      in_rs    = rs;
      drv_exp  = '{r: er, e: ee};
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_pending", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      errors    = 0;
      checks    = 0;
      held_v    = 1'b0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_shamt  = '0;
      in_rs     = '0;
      out_ready = 1'b1;
      drv_exp   = '0;

      //          op      a             sh     rs            expected      err
      tbl[0]  = '{3'b010, 32'h80000010, 5'd4,  32'h00000000, 32'hF8000001, 1'b0};
      tbl[1]  = '{3'b100, 32'h00000001, 5'd0,  32'hFFFFFFFF, 32'h80000000, 1'b0};
`ifdef SHIFT_ROTATE_EN
      tbl[2]  = '{3'b111, 32'h12345678, 5'd0,  32'h00000008, 32'h78123456, 1'b0};
      tbl[3]  = '{3'b011, 32'h0000000F, 5'd4,  32'h00000000, 32'hF0000000, 1'b0};
`else
      tbl[2]  = '{3'b111, 32'h12345678, 5'd0,  32'h00000008, 32'h00000000, 1'b1};
      tbl[3]  = '{3'b011, 32'h0000000F, 5'd4,  32'h00000000, 32'h00000000, 1'b1};
`endif
      tbl[4]  = '{3'b000, 32'h000000FF, 5'd8,  32'h00000000, 32'h0000FF00, 1'b0};
      tbl[5]  = '{3'b001, 32'hF0000000, 5'd28, 32'h00000000, 32'h0000000F, 1'b0};
      tbl[6]  = '{3'b010, 32'h7FFF0000, 5'd16, 32'h00000000, 32'h00007FFF, 1'b0};
      tbl[7]  = '{3'b110, 32'h80000000, 5'd0,  32'h0000001F, 32'hFFFFFFFF, 1'b0};
      tbl[8]  = '{3'b101, 32'h80000000, 5'd7,  32'hFFFFFFE1, 32'h40000000, 1'b0};
      tbl[9]  = '{3'b000, 32'hDEADBEEF, 5'd0,  32'h00000011, 32'hDEADBEEF, 1'b0};
      tbl[10] = '{3'b010, 32'h80000001, 5'd0,  32'h00000003, 32'h80000001, 1'b0};
      tbl[11] = '{3'b101, 32'hCAFEBABE, 5'd5,  32'h00000020, 32'hCAFEBABE, 1'b0};
      tbl[12] = '{3'b000, 32'h00000001, 5'd1,  32'h00000003, 32'h00000002, 1'b0};
      tbl[13] = '{3'b001, 32'h80000000, 5'd31, 32'h00000000, 32'h00000001, 1'b0};

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      #5 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Two-cycle latency on SRA
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = 3'b010;
      in_a     = 32'h80000010;
      in_shamt = 5'd4;
      drv_exp  = '{r: 32'hF8000001, e: 1'b0};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_cycle2_result", out_result, 32'hF8000001);
      chk("lat_cycle2_err", {31'd0, out_err}, 32'd0);
      drain();

      // Vector table, back-to-back with out_ready high
      @(posedge clk);
      #1;
      for (int i = 0; i < 14; i++)
         send(tbl[i].op, tbl[i].a, tbl[i].sh, tbl[i].rs, tbl[i].er, tbl[i].ee);
      drain();

      // Backpressure: three SRL requests, out_ready low
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = 3'b001;
      in_a      = 32'h80000000; in_shamt = 5'd1;
      drv_exp   = '{r: 32'h40000000, e: 1'b0};
      @(posedge clk);
      #1;
      in_a      = 32'hFFFFFFFF; in_shamt = 5'd4;
      drv_exp   = '{r: 32'h0FFFFFFF, e: 1'b0};
      @(posedge clk);
      #1;
      in_a      = 32'h12345678; in_shamt = 5'd8;
      drv_exp   = '{r: 32'h00123456, e: 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      chk("bp_queued", 32'(sbq.size()), 32'd2);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Flush with both stages full and a new request offered
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(3'b000, 32'h00000003, 5'd2, 32'd0, 32'h0000000C, 1'b0);
      send(3'b000, 32'h00000005, 5'd1, 32'd0, 32'h0000000A, 1'b0);
      in_valid = 1'b1;
      in_op    = 3'b001;
      in_a     = 32'hAAAA5555;
      in_shamt = 5'd3;
      drv_exp  = '{r: 32'h15554AAA, e: 1'b0};
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_no_capture", {31'd0, out_valid}, 32'd0);
      end

      // Asynchronous reset pulse mid-stream
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(3'b001, 32'hFFFF0000, 5'd8, 32'd0, 32'h00FFFF00, 1'b0);
      send(3'b001, 32'h0000FFFF, 5'd4, 32'd0, 32'h00000FFF, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_result", out_result, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("arst_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Pipeline still works after the reset pulse
      @(posedge clk);
      #1;
      send(3'b110, 32'h80000000, 5'd0, 32'h00000004, 32'hF8000000, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
